// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// Width limits live here so every instantiating block agrees on them.
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MAX_WIDTH     = 64;

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder cell, the link of the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// Registered WIDTH-bit adder: ripple chain of full_adder_cell feeding one
// output register stage with a synchronous clear.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    // Out-of-range widths would silently build a useless or huge chain.
    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
        $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    assign w_carry[0] = cin;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chain
        full_adder_cell u_cell (
            .a  (a[g]),
            .b  (b[g]),
            .ci (w_carry[g]),
            .s  (w_sum[g]),
            .co (w_carry[g+1])
        );
    end

    // Reset wins over data; otherwise the register loads every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_sum   <= w_sum;
            r_carry <= w_carry[WIDTH];
        end
    end

    assign sum   = r_sum;
    assign carry = r_carry;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Scoreboard bench: drives a 1-bit and an 8-bit adder side by side and
// checks both against plain integer addition with one cycle of latency.
`timescale 1ns/100ps
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, cin1, sum1, carry1;
    logic [7:0] a8, b8, sum8;
    logic       cin8, carry8;

    logic [1:0] q1[$];
    logic [8:0] q8[$];

    int totalChecks = 0;
    int badChecks   = 0;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .sum   (sum1),
        .carry (carry1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .sum   (sum8),
        .carry (carry8)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [8:0] got,
                               input logic [8:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and record what the
    // adders must show after the following rising edge.
    task automatic applyStimulus(input logic r, input logic xa1, input logic xb1,
                                 input logic xc1, input logic [7:0] xa8,
                                 input logic [7:0] xb8, input logic xc8,
                                 input bit glitch);
        int s1, s8;
        @(negedge clk);
        rst  = r;
        a1   = xa1;  b1 = xb1;  cin1 = xc1;
        a8   = xa8;  b8 = xb8;  cin8 = xc8;
        s1   = int'(xa1) + int'(xb1) + int'(xc1);
        s8   = int'(xa8) + int'(xb8) + int'(xc8);
        q1.push_back(r ? 2'd0 : 2'(s1));
        q8.push_back(r ? 9'd0 : 9'(s8));
        if (glitch) begin
            @(posedge clk);
            #2;
            a1 = ~a1;  b1 = $urandom_range(0, 1);
            a8 = 8'($urandom);  b8 = ~b8;  cin8 = ~cin8;
            #0.5;
            rst = 1'b1;
            #0.5;
            rst = r;
        end
    endtask

    // Monitor: pops one expectation per rising edge, then confirms the
    // outputs have not moved by late in the same cycle.
    initial begin : monitor
        logic [1:0] e1;
        logic [8:0] e8;
        bit         popped;
        forever begin
            @(posedge clk);
            #1;
            popped = 1'b0;
            if (q1.size() > 0 && q8.size() > 0) begin
                e1 = q1.pop_front();
                e8 = q8.pop_front();
                checkOutput("w1_result", {7'd0, carry1, sum1}, {7'd0, e1});
                checkOutput("w8_result", {carry8, sum8}, e8);
                popped = 1'b1;
            end
            #3;
            if (popped) begin
                checkOutput("w1_hold", {7'd0, carry1, sum1}, {7'd0, e1});
                checkOutput("w8_hold", {carry8, sum8}, e8);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;

        $display("[TB] reset held for 10 cycles");
        repeat (10) applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);

        $display("[TB] directed sweep and 8-bit carry boundaries");
        applyStimulus(0, 1, 0, 0, 8'hFF, 8'h01, 0, 0);
        applyStimulus(0, 0, 1, 0, 8'h7F, 8'h80, 1, 0);
        applyStimulus(0, 1, 1, 0, 8'hFF, 8'hFF, 1, 0);

        $display("[TB] exhaustive 1-bit combinations");
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            applyStimulus(0, v[2], v[1], v[0], 8'($urandom), 8'($urandom),
                          1'($urandom), 0);
        end

        $display("[TB] reset with live data");
        repeat (3) applyStimulus(1, 1, 1, 1, 8'hFF, 8'hFF, 1, 0);
        applyStimulus(0, 1, 1, 0, 8'h80, 8'h80, 0, 0);

        $display("[TB] glitching inputs and reset between edges");
        for (int i = 0; i < 20; i++)
            applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom),
                          8'($urandom), 8'($urandom), 1'($urandom), 1);

        $display("[TB] random vectors");
        for (int i = 0; i < 1000; i++)
            applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom),
                          1'($urandom), 1'($urandom), 8'($urandom),
                          8'($urandom), 1'($urandom), 0);

        repeat (2) @(posedge clk);
        #3;
        checkOutput("queue_drained", 9'(q1.size() + q8.size()), 9'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule : tb_full_adder
